// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Runtime-programmable clock/strobe divider. Divides i_clk_in by a divisor
// D loaded at run time. Each period is exactly D input cycles: a LOW phase of
// D - (D>>1) cycles followed by a HIGH phase of D>>1 cycles. Besides the
// divided level, single-cycle rise/fall strobes are produced so downstream
// logic can stay on i_clk_in and use them as clock enables.
//
// A new divisor is held as pending and takes effect at the next period
// boundary (end of HIGH), or immediately on restart, so the output never
// shows a truncated or stretched phase.
//
// Ports
//   i_clk_in      : single clock, all logic on the rising edge
//   i_rst         : synchronous reset, active low
//   i_en          : count enable; counter, phase and o_clk_out freeze at 0
//   i_restart     : synchronous restart to LOW cycle 0 of a new period
//   i_div_load    : one-cycle request to load i_div_in
//   i_div_in      : requested divisor (values 0 and 1 are rejected)
//   o_clk_out     : divided level, registered
//   o_tick_rise   : high in the first cycle o_clk_out is 1
//   o_tick_fall   : high in the first cycle o_clk_out is 0 after a HIGH phase
//   o_div_active  : divisor currently in effect
//   o_pending     : a loaded divisor is waiting for the next boundary
//   o_load_err    : one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic             i_div_load,
    input  logic [WIDTH-1:0] i_div_in,
    output logic             o_clk_out,
    output logic             o_tick_rise,
    output logic             o_tick_fall,
    output logic [WIDTH-1:0] o_div_active,
    output logic             o_pending,
    output logic             o_load_err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // Phase lengths. LOW takes the extra cycle of an odd divisor.
    function automatic logic [WIDTH-1:0] low_len(input logic [WIDTH-1:0] d);
        return d - (d >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] d);
        return d >> 1;
    endfunction

    phase_e           r_phase;
    phase_e           w_phase_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_div_active;
    logic [WIDTH-1:0] w_div_active_nxt;
    logic [WIDTH-1:0] r_pend_val;
    logic [WIDTH-1:0] w_pend_val_nxt;
    logic             r_pending;
    logic             w_pending_nxt;
    logic             r_clk_out;
    logic             w_clk_out_nxt;
    logic             r_tick_rise;
    logic             w_tick_rise_nxt;
    logic             r_tick_fall;
    logic             w_tick_fall_nxt;
    logic             r_load_err;
    logic             w_load_err_nxt;

    logic             w_load_ok;
    logic             w_load_bad;
    logic [WIDTH-1:0] w_len_m1;
    logic             w_last;
    logic             w_boundary;
    logic [WIDTH-1:0] w_next_div;

    // A divisor is valid when any bit above bit 0 is set, i.e. D >= 2.
    assign w_load_ok  = i_div_load & (|i_div_in[WIDTH-1:1]);
    assign w_load_bad = i_div_load & ~(|i_div_in[WIDTH-1:1]);

    // Phase lengths are at least 1 for any D >= 2, so len-1 never underflows.
    assign w_len_m1 = (r_phase == PH_LOW) ? (low_len(r_div_active) - ONE)
                                          : (high_len(r_div_active) - ONE);
    assign w_last   = (r_cnt == w_len_m1);

    // Divisor to adopt at a boundary or restart: a valid same-cycle load
    // wins over a stored pending value, which wins over the current one.
    assign w_next_div = w_load_ok ? i_div_in
                                  : (r_pending ? r_pend_val : r_div_active);

    always_comb begin
        w_phase_nxt      = r_phase;
        w_cnt_nxt        = r_cnt;
        w_clk_out_nxt    = r_clk_out;
        w_tick_rise_nxt  = 1'b0;
        w_tick_fall_nxt  = 1'b0;
        w_div_active_nxt = r_div_active;
        w_pending_nxt    = r_pending;
        w_pend_val_nxt   = r_pend_val;
        w_load_err_nxt   = w_load_bad;
        w_boundary       = 1'b0;

        if (i_restart) begin
            // Restart ignores i_en and adopts any waiting divisor at once.
            w_phase_nxt      = PH_LOW;
            w_cnt_nxt        = ZERO;
            w_clk_out_nxt    = 1'b0;
            w_tick_fall_nxt  = r_clk_out;
            w_div_active_nxt = w_next_div;
            w_pending_nxt    = 1'b0;
        end else begin
            if (i_en) begin
                if (w_last) begin
                    w_cnt_nxt = ZERO;
                    if (r_phase == PH_LOW) begin
                        w_phase_nxt     = PH_HIGH;
                        w_clk_out_nxt   = 1'b1;
                        w_tick_rise_nxt = 1'b1;
                    end else begin
                        // End of HIGH is the period boundary.
                        w_phase_nxt      = PH_LOW;
                        w_clk_out_nxt    = 1'b0;
                        w_tick_fall_nxt  = 1'b1;
                        w_boundary       = 1'b1;
                        w_div_active_nxt = w_next_div;
                        w_pending_nxt    = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end

            // Loads not consumed by a boundary are parked; last one wins.
            if (w_load_ok && !w_boundary) begin
                w_pend_val_nxt = i_div_in;
                w_pending_nxt  = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge i_clk_in) begin
        if (!i_rst) begin
            r_phase      <= PH_LOW;
            r_cnt        <= ZERO;
            r_clk_out    <= 1'b0;
            r_tick_rise  <= 1'b0;
            r_tick_fall  <= 1'b0;
            r_div_active <= DEF_DIV;
            r_pending    <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_clk_out    <= w_clk_out_nxt;
            r_tick_rise  <= w_tick_rise_nxt;
            r_tick_fall  <= w_tick_fall_nxt;
            r_div_active <= w_div_active_nxt;
            r_pending    <= w_pending_nxt;
            r_load_err   <= w_load_err_nxt;
        end
    end

    // The stored divisor is only meaningful while r_pending is set, so it
    // needs no reset; clearing r_pending discards it.
    always_ff @(posedge i_clk_in) begin
        r_pend_val <= w_pend_val_nxt;
    end

    assign o_clk_out    = r_clk_out;
    assign o_tick_rise  = r_tick_rise;
    assign o_tick_fall  = r_tick_fall;
    assign o_div_active = r_div_active;
    assign o_pending    = r_pending;
    assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//
// Testbench for clk_div_prog (WIDTH=16, DEFAULT_DIV=4). A table of
// per-cycle input/expected-output records covers reset, even/odd divisors,
// deferred and same-boundary loads, rejected loads, enable gating, restart
// and reset precedence. Expected outputs are queued as each record is
// driven and popped after the clock edge that should produce them. A short
// hand-written sequence then measures phase lengths for D=7 by counting
// edges between strobes.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int W = 16;

    logic         clk;
    logic         i_rst;
    logic         i_en;
    logic         i_restart;
    logic         i_div_load;
    logic [W-1:0] i_div_in;
    logic         o_clk_out;
    logic         o_tick_rise;
    logic         o_tick_fall;
    logic [W-1:0] o_div_active;
    logic         o_pending;
    logic         o_load_err;

    clk_div_prog #(
        .WIDTH      (W),
        .DEFAULT_DIV(4)
    ) dut (
        .i_clk_in    (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_restart   (i_restart),
        .i_div_load  (i_div_load),
        .i_div_in    (i_div_in),
        .o_clk_out   (o_clk_out),
        .o_tick_rise (o_tick_rise),
        .o_tick_fall (o_tick_fall),
        .o_div_active(o_div_active),
        .o_pending   (o_pending),
        .o_load_err  (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic         rs;
        logic         ld;
        logic [W-1:0] din;
        logic         c;
        logic         r;
        logic         f;
        logic [W-1:0] act;
        logic         p;
        logic         e;
    } vec_t;

    vec_t          vecs[$];
    logic [W+4:0]  exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic add(input bit rst, input bit en, input bit rs, input bit ld,
                       input int din, input bit c, input bit r, input bit f,
                       input int act, input bit p, input bit e);
        vec_t v;
        v.rst = rst; v.en = en; v.rs = rs; v.ld = ld; v.din = W'(din);
        v.c = c; v.r = r; v.f = f; v.act = W'(act); v.p = p; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W+4:0] got,
                         input logic [W+4:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got clk=%b rise=%b fall=%b act=%0d pend=%b err=%b, expected clk=%b rise=%b fall=%b act=%0d pend=%b err=%b",
                     name, got[W+4], got[W+3], got[W+2], got[W+1:2], got[1], got[0],
                     exp[W+4], exp[W+3], exp[W+2], exp[W+1:2], exp[1], exp[0]);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [W+4:0] dut_out();
        return {o_clk_out, o_tick_rise, o_tick_fall, o_div_active, o_pending, o_load_err};
    endfunction

    // Counts enabled edges until the requested strobe appears (bounded).
    task automatic measure(input bit want_rise, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(want_rise ? o_tick_rise : o_tick_fall) && n < 100);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W+4:0] exp;
        int           n;

        i_rst = 1'b0; i_en = 1'b1; i_restart = 1'b0;
        i_div_load = 1'b0; i_div_in = '0;

        // rst en rs ld din | clk rise fall act pend err
        // Reset, then D=4 default: clk 0,0,1,1,0,... rise at 2/6, fall at 4/8
        add(0,1,0,0,0,  0,0,0,4,0,0);
        add(0,1,0,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  1,1,0,4,0,0);
        add(1,1,0,0,0,  1,0,0,4,0,0);
        add(1,1,0,0,0,  0,0,1,4,0,0);
        add(1,1,0,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  1,1,0,4,0,0);
        add(1,1,0,0,0,  1,0,0,4,0,0);
        add(1,1,0,0,0,  0,0,1,4,0,0);
        // Deferred load of 8 mid-HIGH; period finishes at 4, then 8 (4+4)
        add(1,1,0,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  1,1,0,4,0,0);
        add(1,1,0,1,8,  1,0,0,4,1,0);
        add(1,1,0,0,0,  0,0,1,8,0,0);
        add(1,1,0,0,0,  0,0,0,8,0,0);
        add(1,1,0,0,0,  0,0,0,8,0,0);
        add(1,1,0,0,0,  0,0,0,8,0,0);
        add(1,1,0,0,0,  1,1,0,8,0,0);
        // Loads of 6 then 10 before the boundary: 10 applies
        add(1,1,0,1,6,  1,0,0,8,1,0);
        add(1,1,0,1,10, 1,0,0,8,1,0);
        add(1,1,0,0,0,  1,0,0,8,1,0);
        add(1,1,0,0,0,  0,0,1,10,0,0);
        // D=10: LOW 5, HIGH 5; load 2 on the boundary cycle applies directly
        add(1,1,0,0,0,  0,0,0,10,0,0);
        add(1,1,0,0,0,  0,0,0,10,0,0);
        add(1,1,0,0,0,  0,0,0,10,0,0);
        add(1,1,0,0,0,  0,0,0,10,0,0);
        add(1,1,0,0,0,  1,1,0,10,0,0);
        add(1,1,0,0,0,  1,0,0,10,0,0);
        add(1,1,0,0,0,  1,0,0,10,0,0);
        add(1,1,0,0,0,  1,0,0,10,0,0);
        add(1,1,0,0,0,  1,0,0,10,0,0);
        add(1,1,0,1,2,  0,0,1,2,0,0);
        // D=2: LOW 1, HIGH 1
        add(1,1,0,0,0,  1,1,0,2,0,0);
        add(1,1,0,0,0,  0,0,1,2,0,0);
        add(1,1,0,0,0,  1,1,0,2,0,0);
        add(1,1,0,0,0,  0,0,1,2,0,0);
        // Odd D=5: LOW 3, HIGH 2
        add(1,1,0,1,5,  1,1,0,2,1,0);
        add(1,1,0,0,0,  0,0,1,5,0,0);
        add(1,1,0,0,0,  0,0,0,5,0,0);
        add(1,1,0,0,0,  0,0,0,5,0,0);
        add(1,1,0,0,0,  1,1,0,5,0,0);
        add(1,1,0,0,0,  1,0,0,5,0,0);
        add(1,1,0,0,0,  0,0,1,5,0,0);
        add(1,1,0,0,0,  0,0,0,5,0,0);
        add(1,1,0,0,0,  0,0,0,5,0,0);
        add(1,1,0,0,0,  1,1,0,5,0,0);
        add(1,1,0,0,0,  1,0,0,5,0,0);
        add(1,1,0,0,0,  0,0,1,5,0,0);
        // Odd D=3: LOW 2, HIGH 1
        add(1,1,0,1,3,  0,0,0,5,1,0);
        add(1,1,0,0,0,  0,0,0,5,1,0);
        add(1,1,0,0,0,  1,1,0,5,1,0);
        add(1,1,0,0,0,  1,0,0,5,1,0);
        add(1,1,0,0,0,  0,0,1,3,0,0);
        add(1,1,0,0,0,  0,0,0,3,0,0);
        add(1,1,0,0,0,  1,1,0,3,0,0);
        add(1,1,0,0,0,  0,0,1,3,0,0);
        add(1,1,0,0,0,  0,0,0,3,0,0);
        add(1,1,0,0,0,  1,1,0,3,0,0);
        add(1,1,0,0,0,  0,0,1,3,0,0);
        // Rejected loads (1, 0), including one while 4 is pending
        add(1,1,0,1,1,  0,0,0,3,0,1);
        add(1,1,0,1,0,  1,1,0,3,0,1);
        add(1,1,0,0,0,  0,0,1,3,0,0);
        add(1,1,0,1,4,  0,0,0,3,1,0);
        add(1,1,0,1,1,  1,1,0,3,1,1);
        add(1,1,0,0,0,  0,0,1,4,0,0);
        // Enable dropped 7 cycles mid-LOW, then the remaining count resumes
        add(1,1,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,0,0,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  1,1,0,4,0,0);
        add(1,1,0,0,0,  1,0,0,4,0,0);
        add(1,1,0,0,0,  0,0,1,4,0,0);
        // Restart mid-HIGH with 6 pending: fall now, then a 6-cycle period
        add(1,1,0,1,6,  0,0,0,4,1,0);
        add(1,1,0,0,0,  1,1,0,4,1,0);
        add(1,1,1,0,0,  0,0,1,6,0,0);
        add(1,1,0,0,0,  0,0,0,6,0,0);
        add(1,1,0,0,0,  0,0,0,6,0,0);
        add(1,1,0,0,0,  1,1,0,6,0,0);
        add(1,1,0,0,0,  1,0,0,6,0,0);
        add(1,1,0,0,0,  1,0,0,6,0,0);
        add(1,1,0,0,0,  0,0,1,6,0,0);
        // Restart during LOW with en=0: no fall strobe, count restarts
        add(1,1,0,0,0,  0,0,0,6,0,0);
        add(1,0,1,0,0,  0,0,0,6,0,0);
        add(1,1,0,0,0,  0,0,0,6,0,0);
        add(1,1,0,0,0,  0,0,0,6,0,0);
        add(1,1,0,0,0,  1,1,0,6,0,0);
        // Restart with a same-cycle valid load applies it at once
        add(1,1,1,1,2,  0,0,1,2,0,0);
        add(1,1,0,0,0,  1,1,0,2,0,0);
        add(1,1,0,0,0,  0,0,1,2,0,0);
        // rst together with restart while 8 pending: reset state wins
        add(1,1,0,1,8,  1,1,0,2,1,0);
        add(0,1,1,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  0,0,0,4,0,0);
        add(1,1,0,0,0,  1,1,0,4,0,0);

        foreach (vecs[i]) begin
            i_rst      = vecs[i].rst;
            i_en       = vecs[i].en;
            i_restart  = vecs[i].rs;
            i_div_load = vecs[i].ld;
            i_div_in   = vecs[i].din;
            exp_q.push_back({vecs[i].c, vecs[i].r, vecs[i].f, vecs[i].act,
                             vecs[i].p, vecs[i].e});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            check($sformatf("vec%0d", i), dut_out(), exp);
        end

        // Hand sequence: restart with D=7 from mid-HIGH, then measure phases
        i_rst = 1'b1; i_en = 1'b1; i_restart = 1'b1;
        i_div_load = 1'b1; i_div_in = W'(7);
        @(posedge clk); #1;
        check("restart_load7", dut_out(), {1'b0, 1'b0, 1'b1, W'(7), 1'b0, 1'b0});
        i_restart = 1'b0; i_div_load = 1'b0; i_div_in = '0;

        measure(1'b1, n);
        check_int("d7_low_len", n, 4);
        measure(1'b0, n);
        check_int("d7_high_len", n, 3);
        measure(1'b1, n);
        check_int("d7_low_len_2", n, 4);
        check_int("d7_clk_high", int'(o_clk_out), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
